memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Pipeline MEM stage of the RV32I core: accepts the registered execute-stage bundle, performs load/store transactions on the data-memory port with a req/ack handshake, aligns and sign/zero-extends load data, and registers the `Memory_Bundle` consumed by the writeback result mux. It stalls upstream while a memory transaction is outstanding and inserts a bubble downstream until the transaction completes.

## Interface
- No parameters; widths are fixed at XLEN = 32.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `EB` input `Execute_Bundle`: fields Valid, ALUResult (address/result), WriteData, rd, RegW, MemRead, MemWrite, Funct3[2:0], ResultSelect, PC4.
- `MemStall` output 1: upstream must hold `EB` stable while high.
- `DReq` output 1: data-memory request.
- `DWE` output 1: 1 = store, 0 = load.
- `DAddr` output 32: word-aligned address, with bits [1:0] = 0.
- `DWData` output 32: store data, lane-replicated.
- `DByteEn` output 4: store byte enables. All ones for loads.
- `DRData` input 32: load data, valid when `DAck` = 1.
- `DAck` input 1: completes the current request.
- `MB` output `Memory_Bundle`: registered. Fields Valid, ALUResult, FinalDataMemoryRead, PC4, rd, RegW, ResultSelect.
- `MisalignErr` output 1: one-cycle pulse. Exists only with the macro (see Configuration).

## Operation
- FSM states: IDLE and WAIT.
- IDLE with `EB.Valid` and (MemRead or MemWrite):
  - Drive `DReq` = 1 combinationally from `EB`.
  - If `DAck` = 1 in the same cycle, complete the transaction and stay in IDLE.
  - Otherwise latch the request fields into internal holding registers and go to WAIT.
- WAIT: `DReq`, `DWE`, `DAddr`, `DWData` and `DByteEn` come from the holding registers and stay stable until `DAck`. On `DAck`, complete the transaction and return to IDLE.
- Handshake rule: `DReq` never deasserts before `DAck`. `DAck` while `DReq` = 0 is ignored.
- Store lanes, with `a` = ALUResult[1:0]:
  - SB (000): DByteEn = 0001 << a; DWData = byte replicated ×4.
  - SH (001): DByteEn = 0011 << a; DWData = half replicated ×2.
  - SW (010): DByteEn = 1111.
- Load extract, shifting DRData right by 8·a:
  - LB: sign-extend byte.
  - LH: sign-extend half.
  - LW: full word.
  - LBU: zero-extend byte.
  - LHU: zero-extend half.
  - Result goes to MB.FinalDataMemoryRead.
- Non-memory valid ops pass through in one cycle with no handshake. MB.FinalDataMemoryRead = 0 for them.
- Stores complete with MB.RegW = 0 regardless of EB.RegW.
- A bubble is MB.Valid = 0 and MB.RegW = 0. It is written on every edge where `MemStall` = 1 or `EB.Valid` = 0.

## Timing
- Reset, on a rising edge with `rst_n` = 0:
  - FSM goes to IDLE and the holding registers clear.
  - All MB fields become 0.
  - `DReq`, `DWE`, `DAddr`, `DWData`, `DByteEn` and `MemStall` are 0 from that edge on.
- Reset mid-transaction abandons the request. `DReq` drops after the reset edge, and any later `DAck` is ignored.
- `MemStall` = `DReq` & ~`DAck`. It is combinational, so there is no stall with zero-wait memory.
- Latency:
  - Non-memory op: MB valid at the next edge.
  - Memory op: MB valid at the edge following the `DAck` cycle.
  - Zero-wait memory sustains one instruction per cycle.
- Back-to-back memory ops: the next op is accepted in the cycle after completion.

## Configuration
- Macro: `MEM_MISALIGN_TRAP_EN`.
- With the macro defined, a misaligned access is one where LH/LHU/SH has a[0] ≠ 0, or LW/SW has a ≠ 00. For such an access:
  - No `DReq` is issued.
  - `MisalignErr` pulses for one cycle, coincident with the MB update.
  - MB.Valid = 1 and MB.RegW = 0.
- Without the macro:
  - The `MisalignErr` port is absent.
  - Low address bits are masked: halfword uses a[1] only, word ignores a.
  - The access proceeds normally.

## Structure
- The shared package `Pkg` holds:
  - `Execute_Bundle` and `Memory_Bundle`, the latter with the Valid field added.
  - Load/store Funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - The `mem_state_t` enum.
- Sub-module `load_extend_unit` is the combinational extract/extend from DRData, Funct3 and a.

## Test plan
- Reset: hold `rst_n` = 0 with EB.Valid = 1, LW → DReq = 0, MB = 0, MemStall = 0.
- Zero-wait LW at 0x100 with DAck the same cycle, DRData = 0xDEADBEEF → no stall; next edge MB.FinalDataMemoryRead = 0xDEADBEEF, MB.RegW = 1.
- LB at 0x103 with DRData = 0x80000000 and DAck 3 cycles late → MemStall high 3 cycles with MB bubbles; DReq/DAddr = 0x100 held stable; result 0xFFFFFF80. The same access as LBU → 0x00000080.
- SH at 0x202, WriteData = 0x1234ABCD → DWE = 1, DByteEn = 1100, DWData = 0xABCDABCD, DAddr = 0x200, MB.RegW = 0.
- Assert `rst_n` = 0 while in WAIT, then DAck one cycle later → FSM in IDLE, no MB update, DReq = 0.
- Macro build, LW at 0x101 → no DReq, MisalignErr pulse, MB.RegW = 0. Non-macro build → DAddr = 0x100 and the load completes.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// Shared types for the RV32I MEM stage: stage bundles, load/store
// Funct3 codes, MEM FSM states and small address-lane helpers.
package Pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic            Valid;
        logic [XLEN-1:0] ALUResult;
        logic [XLEN-1:0] WriteData;
        logic [4:0]      rd;
        logic            RegW;
        logic            MemRead;
        logic            MemWrite;
        logic [2:0]      Funct3;
        logic [1:0]      ResultSelect;
        logic [XLEN-1:0] PC4;
    } Execute_Bundle;

    typedef struct packed {
        logic            Valid;
        logic [XLEN-1:0] ALUResult;
        logic [XLEN-1:0] FinalDataMemoryRead;
        logic [XLEN-1:0] PC4;
        logic [4:0]      rd;
        logic            RegW;
        logic [1:0]      ResultSelect;
    } Memory_Bundle;

    // Byte lane actually used: halfwords keep a[1], words start at lane 0
    function automatic logic [1:0] lane_off(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic [1:0] r;
        r = a;
        unique case (f3[1:0])
            2'b00:   r = a;
            2'b01:   r = {a[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // True when the low address bits do not match the access size
    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic m;
        m = 1'b0;
        unique case (f3[1:0])
            2'b01:   m = a[0];
            2'b10:   m = |a;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/memory_access_stage_load_extend.sv
// Load data aligner: picks the addressed byte/half/word out of the
// memory read word and sign- or zero-extends it to 32 bits.
module load_extend_unit
    import Pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  a,
    output logic [31:0] result
);

    logic [31:0] sh;

    // Shift the addressed lane down to bit 0, then extend by size
    always_comb begin
        sh     = rdata >> {a, 3'b000};
        result = sh;
        unique case (funct3)
            F3_B:    result = {{24{sh[7]}}, sh[7:0]};
            F3_H:    result = {{16{sh[15]}}, sh[15:0]};
            F3_W:    result = sh;
            F3_BU:   result = {24'b0, sh[7:0]};
            F3_HU:   result = {16'b0, sh[15:0]};
            default: result = sh;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// RV32I MEM stage: data-memory req/ack handshake, store lane steering,
// load extract, registered Memory_Bundle. Option: MEM_MISALIGN_TRAP_EN.
module memory_access_stage
    import Pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  Execute_Bundle EB,
    output logic          MemStall,
    output logic          DReq,
    output logic          DWE,
    output logic [31:0]   DAddr,
    output logic [31:0]   DWData,
    output logic [3:0]    DByteEn,
    input  logic [31:0]   DRData,
    input  logic          DAck,
    output Memory_Bundle  MB
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic          MisalignErr
`endif
);

    mem_state_t   state_q, state_d;
    logic         hold_we_q, hold_we_d;
    logic [31:0]  hold_addr_q, hold_addr_d;
    logic [31:0]  hold_wdata_q, hold_wdata_d;
    logic [3:0]   hold_be_q, hold_be_d;
    Memory_Bundle mb_q, mb_d;

    logic [1:0]  a;
    logic [1:0]  ae;
    logic        is_mem;
    logic        mis;
    logic        go;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign a      = EB.ALUResult[1:0];
    assign ae     = lane_off(EB.Funct3, a);
    assign is_mem = EB.Valid & (EB.MemRead | EB.MemWrite);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = misaligned(EB.Funct3, a);
`else
    assign mis = 1'b0;
`endif

    assign go = is_mem & ~mis;

    load_extend_unit u_lext (
        .rdata  (DRData),
        .funct3 (EB.Funct3),
        .a      (ae),
        .result (ld_data)
    );

    // Store byte enables and lane-replicated write data from EB
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = EB.WriteData;
        if (EB.MemWrite) begin
            unique case (EB.Funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << ae;
                    st_wdata = {4{EB.WriteData[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << ae;
                    st_wdata = {2{EB.WriteData[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = EB.WriteData;
                end
            endcase
        end
    end

    // Handshake FSM: next state, holding registers and port drive
    always_comb begin
        state_d      = state_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_be_d    = hold_be_q;
        DReq         = 1'b0;
        DWE          = 1'b0;
        DAddr        = 32'b0;
        DWData       = 32'b0;
        DByteEn      = 4'b0;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    DReq    = 1'b1;
                    DWE     = EB.MemWrite;
                    DAddr   = {EB.ALUResult[31:2], 2'b00};
                    DWData  = st_wdata;
                    DByteEn = st_be;
                    if (!DAck) begin
                        state_d      = WAIT;
                        hold_we_d    = EB.MemWrite;
                        hold_addr_d  = {EB.ALUResult[31:2], 2'b00};
                        hold_wdata_d = st_wdata;
                        hold_be_d    = st_be;
                    end
                end
            end
            WAIT: begin
                DReq    = 1'b1;
                DWE     = hold_we_q;
                DAddr   = hold_addr_q;
                DWData  = hold_wdata_q;
                DByteEn = hold_be_q;
                if (DAck) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A request in reset is abandoned outright
        if (!rst_n) begin
            DReq    = 1'b0;
            DWE     = 1'b0;
            DAddr   = 32'b0;
            DWData  = 32'b0;
            DByteEn = 4'b0;
        end
    end

    assign MemStall = DReq & ~DAck;

    // Next MB: bubble on stall or invalid input, else the retired op
    always_comb begin
        mb_d = '0;
        if (!MemStall && EB.Valid) begin
            mb_d.Valid        = 1'b1;
            mb_d.ALUResult    = EB.ALUResult;
            mb_d.PC4          = EB.PC4;
            mb_d.rd           = EB.rd;
            mb_d.ResultSelect = EB.ResultSelect;
            mb_d.RegW         = EB.RegW & ~EB.MemWrite;
            if (is_mem && mis) begin
                mb_d.RegW = 1'b0;
            end else if (EB.MemRead && !EB.MemWrite) begin
                mb_d.FinalDataMemoryRead = ld_data;
            end
        end
    end

    // State, holding and pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= 32'b0;
            hold_wdata_q <= 32'b0;
            hold_be_q    <= 4'b0;
            mb_q         <= '0;
        end else begin
            state_q      <= state_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_be_q    <= hold_be_d;
            mb_q         <= mb_d;
        end
    end

    assign MB = mb_q;

`ifdef MEM_MISALIGN_TRAP_EN
    logic err_q, err_d;

    assign err_d = is_mem & mis;

    // Trap flag pulses on the same edge that writes the rejected op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign MisalignErr = err_q;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed table, reset corner cases
// and random ops against a size/offset arithmetic model.
module tb_memory_access_stage;
    import Pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    Execute_Bundle EB;
    logic          MemStall, DReq, DWE;
    logic [31:0]   DAddr, DWData, DRData;
    logic [3:0]    DByteEn;
    logic          DAck;
    Memory_Bundle  MB;
`ifdef MEM_MISALIGN_TRAP_EN
    logic          MisalignErr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EB       (EB),
        .MemStall (MemStall),
        .DReq     (DReq),
        .DWE      (DWE),
        .DAddr    (DAddr),
        .DWData   (DWData),
        .DByteEn  (DByteEn),
        .DRData   (DRData),
        .DAck     (DAck),
        .MB       (MB)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .MisalignErr (MisalignErr)
`endif
    );

    task automatic chk(input string n, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    function automatic Execute_Bundle mk(input logic v, input logic [2:0] f3,
                                         input logic rd_, input logic wr,
                                         input logic [31:0] addr,
                                         input logic [31:0] wd);
        Execute_Bundle e;
        e.Valid        = v;
        e.ALUResult    = addr;
        e.WriteData    = wd;
        e.rd           = 5'($urandom);
        e.RegW         = 1'b1;
        e.MemRead      = rd_;
        e.MemWrite     = wr;
        e.Funct3       = f3;
        e.ResultSelect = 2'($urandom);
        e.PC4          = $urandom;
        return e;
    endfunction

    // Reference: access size in bytes, lane offset, arithmetic extension
    task automatic model(input Execute_Bundle e, input logic [31:0] rdv,
                         output logic [31:0] xd, output logic [3:0] xbe,
                         output logic [31:0] xwd, output logic xmis);
        int sz, a, ae;
        longint v, full;
        logic mem;
        mem = e.Valid && (e.MemRead || e.MemWrite);
        sz = (e.Funct3[1:0] == 2'd0) ? 1 : (e.Funct3[1:0] == 2'd1) ? 2 : 4;
        a  = int'(e.ALUResult & 32'h3);
        xmis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        xmis = mem && ((a % sz) != 0);
`endif
        ae   = a - (a % sz);
        full = longint'(1) << (8 * sz);
        v    = (longint'(rdv) >> (8 * ae)) & (full - 1);
        if (!e.Funct3[2] && sz < 4 && v >= full / 2) v = v - full;
        xd  = (mem && e.MemRead && !xmis) ? v[31:0] : 32'h0;
        xbe = e.MemWrite ? 4'(((1 << sz) - 1) << ae) : 4'hF;
        if (sz == 1) xwd = (e.WriteData & 32'hFF) * 32'h01010101;
        else if (sz == 2) xwd = (e.WriteData & 32'hFFFF) * 32'h00010001;
        else xwd = e.WriteData;
    endtask

    // Drive one op; memory acks after lat wait cycles; check ports and MB
    task automatic do_op(input Execute_Bundle e, input logic [31:0] rdv,
                         input int lat, input logic [31:0] xd,
                         input logic [3:0] xbe, input logic [31:0] xwd,
                         input logic xmis);
        logic mem, req;
        int   le;
        mem = e.Valid && (e.MemRead || e.MemWrite);
        req = mem && !xmis;
        le  = req ? lat : 0;
        EB  = e;
        for (int k = 0; k <= le; k++) begin
            DAck   = req ? (k == le) : 1'($urandom);
            DRData = (req && k == le) ? rdv : $urandom;
            #3;
            chk("dreq", 128'(DReq), 128'(req));
            chk("stall", 128'(MemStall), 128'(req && k < le));
            if (req) begin
                chk("dwe", 128'(DWE), 128'(e.MemWrite));
                chk("daddr", 128'(DAddr), 128'(e.ALUResult & 32'hFFFFFFFC));
                chk("dbe", 128'(DByteEn), 128'(xbe));
                if (e.MemWrite) chk("dwdata", 128'(DWData), 128'(xwd));
            end
            @(posedge clk);
            #1;
            if (req && k < le) begin
                chk("bub_valid", 128'(MB.Valid), 128'(0));
                chk("bub_regw", 128'(MB.RegW), 128'(0));
            end
        end
        DAck = 1'b0;
        chk("mb_valid", 128'(MB.Valid), 128'(e.Valid));
        if (e.Valid) begin
            chk("mb_regw", 128'(MB.RegW),
                128'((xmis || e.MemWrite) ? 1'b0 : e.RegW));
            chk("mb_data", 128'(MB.FinalDataMemoryRead), 128'(xd));
            chk("mb_alu", 128'(MB.ALUResult), 128'(e.ALUResult));
            chk("mb_pc4", 128'(MB.PC4), 128'(e.PC4));
            chk("mb_rd", 128'(MB.rd), 128'(e.rd));
            chk("mb_rsel", 128'(MB.ResultSelect), 128'(e.ResultSelect));
        end else begin
            chk("mb_regw_inv", 128'(MB.RegW), 128'(0));
        end
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_err", 128'(MisalignErr), 128'(e.Valid && xmis));
`endif
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        ld;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdv;
        int          lat;
        logic [31:0] xd;
        logic [3:0]  xbe;
        logic [31:0] xwd;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Execute_Bundle e;
        logic [31:0] xd, xwd, rdv;
        logic [3:0]  xbe;
        logic        xmis;

        tbl[0] = '{F3_W,  1, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                   32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1] = '{F3_B,  1, 32'h103, 32'h0, 32'h80000000, 3,
                   32'hFFFFFF80, 4'hF, 32'h0};
        tbl[2] = '{F3_BU, 1, 32'h103, 32'h0, 32'h80000000, 3,
                   32'h00000080, 4'hF, 32'h0};
        tbl[3] = '{F3_H,  0, 32'h202, 32'h1234ABCD, 32'h0, 1,
                   32'h0, 4'hC, 32'hABCDABCD};
        tbl[4] = '{F3_H,  1, 32'h102, 32'h0, 32'h80011234, 0,
                   32'hFFFF8001, 4'hF, 32'h0};
        tbl[5] = '{F3_HU, 1, 32'h102, 32'h0, 32'h80011234, 2,
                   32'h00008001, 4'hF, 32'h0};
        tbl[6] = '{F3_B,  0, 32'h301, 32'h000000A5, 32'h0, 1,
                   32'h0, 4'h2, 32'hA5A5A5A5};
        tbl[7] = '{F3_W,  0, 32'h400, 32'hCAFEF00D, 32'h0, 2,
                   32'h0, 4'hF, 32'hCAFEF00D};
        tbl[8] = '{F3_B,  1, 32'h101, 32'h0, 32'h00007F00, 0,
                   32'h0000007F, 4'hF, 32'h0};

        // Reset held with a valid LW presented
        rst_n  = 1'b0;
        DAck   = 1'b0;
        DRData = 32'h0;
        EB     = mk(1'b1, F3_W, 1'b1, 1'b0, 32'h100, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dreq", 128'(DReq), 128'(0));
        chk("rst_stall", 128'(MemStall), 128'(0));
        chk("rst_mb", 128'(MB), 128'(0));
        EB.Valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            e = mk(1'b1, tbl[i].f3, tbl[i].ld, !tbl[i].ld,
                   tbl[i].addr, tbl[i].wd);
            do_op(e, tbl[i].rdv, tbl[i].lat, tbl[i].xd, tbl[i].xbe,
                  tbl[i].xwd, 1'b0);
        end

        // Non-memory pass-through and bubble
        e = mk(1'b1, F3_W, 1'b0, 1'b0, 32'h12345678, 32'h0);
        do_op(e, 32'h0, 0, 32'h0, 4'hF, 32'h0, 1'b0);
        e = mk(1'b0, F3_W, 1'b1, 1'b0, 32'h100, 32'h0);
        do_op(e, 32'h0, 0, 32'h0, 4'hF, 32'h0, 1'b0);

        // Misaligned LW: trap with macro, masked word access without
        e = mk(1'b1, F3_W, 1'b1, 1'b0, 32'h101, 32'h0);
        model(e, 32'h11223344, xd, xbe, xwd, xmis);
        do_op(e, 32'h11223344, 1, xd, xbe, xwd, xmis);

        // Reset while waiting: request abandoned, late ack ignored
        EB = mk(1'b1, F3_W, 1'b1, 1'b0, 32'h100, 32'h0);
        DAck = 1'b0;
        @(posedge clk);
        #3;
        chk("wait_dreq", 128'(DReq), 128'(1));
        chk("wait_stall", 128'(MemStall), 128'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_dreq", 128'(DReq), 128'(0));
        chk("rstw_mbv", 128'(MB.Valid), 128'(0));
        DAck   = 1'b1;
        DRData = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        chk("rstw_ack_mbv", 128'(MB.Valid), 128'(0));
        chk("rstw_ack_dreq", 128'(DReq), 128'(0));
        rst_n    = 1'b1;
        EB.Valid = 1'b0;
        #3;
        chk("post_rst_dreq", 128'(DReq), 128'(0));
        @(posedge clk);
        #1;
        chk("post_rst_mbv", 128'(MB.Valid), 128'(0));
        DAck = 1'b0;
        e = mk(1'b1, F3_W, 1'b1, 1'b0, 32'h100, 32'h0);
        do_op(e, 32'h0BADF00D, 0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);

        // Random back-to-back ops against the model
        for (int i = 0; i < 80; i++) begin
            int kind;
            logic [2:0] f3;
            kind = $urandom_range(0, 3);
            if (kind == 1) begin
                int s;
                s  = $urandom_range(0, 4);
                f3 = (s == 0) ? F3_B : (s == 1) ? F3_H : (s == 2) ? F3_W :
                     (s == 3) ? F3_BU : F3_HU;
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            e = mk(kind != 3, f3, kind == 1 || kind == 3, kind == 2,
                   $urandom, $urandom);
            rdv = $urandom;
            model(e, rdv, xd, xbe, xwd, xmis);
            do_op(e, rdv, $urandom_range(0, 3), xd, xbe, xwd, xmis);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
